// File: rtl/ac_mul_pkg.sv
// Shared constants and helpers for the quadrant-split approximate multiplier.
// Mode byte layout: {hh[7:6], hl[5:4], lh[3:2], ll[1:0]}.
package ac_mul_pkg;
  localparam int QLVL_W = 2;
  localparam int LL_OFF = 0;
  localparam int LH_OFF = 2;
  localparam int HL_OFF = 4;
  localparam int HH_OFF = 6;

  localparam int Q_HH = 0;
  localparam int Q_HL = 1;
  localparam int Q_LH = 2;
  localparam int Q_LL = 3;

  localparam int MASK_W = 64;

  // Keeps the product bits above min(2*lvl, 2*h); callers truncate to 2*h bits.
  function automatic logic [MASK_W-1:0] lvl_mask(input logic [QLVL_W-1:0] lvl, input int h);
    int n;
    n = 2 * int'(lvl);
    if (n > 2 * h) n = 2 * h;
    return {MASK_W{1'b1}} << n;
  endfunction
endpackage

// File: rtl/ac_quad_mul.sv
// Combinational half-width quadrant multiplier with a per-transaction
// approximation level that zeroes the low product bits.
module ac_quad_mul
  import ac_mul_pkg::*;
#(
  parameter int H = 4
) (
  input  logic [H-1:0]      x,
  input  logic [H-1:0]      y,
  input  logic [QLVL_W-1:0] level,
  output logic [2*H-1:0]    prod
);
  logic [2*H-1:0] w_full;
  logic [2*H-1:0] w_mask;

  assign w_full = {{H{1'b0}}, x} * {{H{1'b0}}, y};
  assign w_mask = (2*H)'(lvl_mask(level, H));
  assign prod   = w_full & w_mask;
endmodule

// File: rtl/ac_pipe_mul.sv
// Three-stage pipelined approximate unsigned multiplier behind a valid/ready stream.
// S1 holds operands/mode/tag, S2 the masked quadrant products, S3 the recombined product.
module ac_pipe_mul
  import ac_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [7:0]           mode,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic [TAG_W-1:0]     tag_out
);
  localparam int H  = WIDTH / 2;
  localparam int QW = 2 * H;

  // Handshake: a transfer happens on a rising edge where valid && ready; an
  // asserted valid holds its data stable until that transfer. Each stage loads
  // when it is empty or the stage after it loads, so bubbles collapse and
  // in_ready reaches back combinationally from out_ready.
  logic w_s1_en, w_s2_en, w_s3_en;

  logic               r_v1, r_v2, r_v3;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [7:0]         r_mode;
  logic [TAG_W-1:0]   r_tag1, r_tag2, r_tag3;
  logic [QW-1:0]      r_q [4];
  logic [2*WIDTH-1:0] r_prod;

  logic [QW-1:0]      w_q [4];
  logic [H-1:0]       w_ah, w_al, w_bh, w_bl;
  logic [QW:0]        w_mid;
  logic [2*WIDTH-1:0] w_prod;

  assign w_s3_en  = !r_v3 || out_ready;
  assign w_s2_en  = !r_v2 || w_s3_en;
  assign w_s1_en  = !r_v1 || w_s2_en;
  assign in_ready = w_s1_en;

  assign w_ah = r_a[WIDTH-1:H];
  assign w_al = r_a[H-1:0];
  assign w_bh = r_b[WIDTH-1:H];
  assign w_bl = r_b[H-1:0];

  ac_quad_mul #(.H(H)) u_q_hh (.x(w_ah), .y(w_bh), .level(r_mode[HH_OFF +: QLVL_W]), .prod(w_q[Q_HH]));
  ac_quad_mul #(.H(H)) u_q_hl (.x(w_ah), .y(w_bl), .level(r_mode[HL_OFF +: QLVL_W]), .prod(w_q[Q_HL]));
  ac_quad_mul #(.H(H)) u_q_lh (.x(w_al), .y(w_bh), .level(r_mode[LH_OFF +: QLVL_W]), .prod(w_q[Q_LH]));
  ac_quad_mul #(.H(H)) u_q_ll (.x(w_al), .y(w_bl), .level(r_mode[LL_OFF +: QLVL_W]), .prod(w_q[Q_LL]));

  // Cross terms summed one bit wider so the carry survives the shift-add.
  assign w_mid  = {1'b0, r_q[Q_HL]} + {1'b0, r_q[Q_LH]};
  assign w_prod = {r_q[Q_HH], {WIDTH{1'b0}}}
                + {{(H-1){1'b0}}, w_mid, {H{1'b0}}}
                + {{WIDTH{1'b0}}, r_q[Q_LL]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_prod <= '0;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else begin
      if (w_s1_en) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_a    <= a;
          r_b    <= b;
          r_mode <= mode;
          r_tag1 <= tag_in;
        end
      end
      if (w_s2_en) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          for (int i = 0; i < 4; i++) r_q[i] <= w_q[i];
          r_tag2 <= r_tag1;
        end
      end
      if (w_s3_en) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_prod <= w_prod;
          r_tag3 <= r_tag2;
        end
      end
    end
  end

  assign out_valid = r_v3;
  assign prod      = r_prod;
  assign tag_out   = r_tag3;
endmodule

// File: doc/ac_pipe_mul.md
# ac_pipe_mul

Parametrised, pipelined approximate unsigned multiplier. The next generation of the 8x8 quadrant-split approximate multiplier, generalised to any even operand width. Each operand is split into high and low halves, and four half-width quadrant products (HH, HL, LH, LL) are recombined by shift-add. Each quadrant's approximation level is chosen per transaction rather than fixed at build time. Sits in the accelerator datapath behind a valid/ready stream and feeds the accumulate stage.

## Interface
Parameters:
- WIDTH, 8, operand width; must be even and at least 4.
- TAG_W, 4, width of the opaque sideband tag carried alongside each product.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- mode  in  8  per-quadrant approximation level, as {hh[7:6], hl[5:4], lh[3:2], ll[1:0]}.
- tag_in  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts the product.
- prod  out  2*WIDTH  product.
- tag_out  out  TAG_W  tag of the transaction currently on prod.

## Operation
- Half width: H = WIDTH/2.
  - ah = a[WIDTH-1:H], al = a[H-1:0]; bh and bl split the same way.
- Quadrant products: qHH = ah*bh, qHL = ah*bl, qLH = al*bh, qLL = al*bl. Each is 2H bits wide.
- Approximation level L (0..3) for a quadrant: the exact quadrant product with its low min(2L, 2H) bits forced to 0.
  - L=0 is exact.
  - The mode field of each quadrant selects its L.
- Recombination: prod = (qHH << WIDTH) + ((qHL + qLH) << H) + qLL.
  - The full 2*WIDTH result is kept.
  - The HL+LH sum is computed at 2H+1 bits, so no truncation occurs anywhere.
- mode and tag_in are captured with the operands. A later change to mode never affects a transaction already in flight.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.

## Timing
- Three register stages:
  - S1 captures a, b, mode and tag.
  - S2 holds the four masked quadrant products.
  - S3 holds prod and tag_out.
- Latency: an input accepted in cycle t appears on prod with out_valid in cycle t+3, provided no stall.
- Throughput: one transaction per cycle while out_ready=1.
- Each stage has its own valid bit. Stage k loads when it is empty or stage k+1 loads (or, for S3, the output transfers).
  - Bubbles collapse.
  - in_ready = !S1.valid || S1 advances.
  - in_ready is combinational from out_ready through the stage valids.
- Stall: with out_ready=0, prod, tag_out and out_valid hold stable. No transaction is dropped or duplicated. in_ready falls only once all three stages are full.
- Simultaneous output transfer and upstream advance in the same cycle: S3 reloads with no bubble.
- Reset: all stage valid bits go to 0, and prod, tag_out and every data register go to 0.
  - in_ready = 1 and out_valid = 0 in the first cycle after rst deasserts.
  - Asserting rst mid-stream discards every in-flight transaction; none is emitted afterwards.
- in_valid is ignored while rst=1.

## Structure
- Shared package ac_mul_pkg holds:
  - the mode field offsets and width (QLVL_W=2);
  - the quadrant index constants Q_HH, Q_HL, Q_LH, Q_LL;
  - a function that builds the low-bit mask from a level and H.
- One sub-module: ac_quad_mul (parameter H; inputs x, y, level; output 2H-bit product).
  - Combinational.
  - Instantiated four times, between S1 and S2.
- The recombination adder sits between S2 and S3, inline in the top module.

## Test plan
- WIDTH=8, a=8'hFF, b=8'hFF, mode=8'h00 -> prod=16'hFE01 exactly 3 cycles after acceptance.
- WIDTH=8, a=8'hFF, b=8'hFF, mode=8'h03 (LL level 3) -> prod=16'hFDE0. mode=8'hFF -> prod=16'hD8C0.
- Back-to-back stream of 20 random operands with random modes and tags, out_ready=1 -> one result per cycle, in order, each matching the reference model, with tags preserved.
- out_ready held 0 for 5 cycles while in_valid=1 -> in_ready drops after 3 accepts; prod and tag_out stay stable. Releasing out_ready drains the results in order with no loss.
- rst asserted for 1 cycle with 3 transactions in flight -> out_valid=0 and prod=0 next cycle, none of the 3 results ever appears, and in_ready=1.
- WIDTH=16, a=16'hFFFF, b=16'h0001, mode=8'h00 -> prod=32'h0000FFFF. A zero operand with any mode -> prod=0.
